// File: rtl/feature_loader_ctrl.sv
// Load sequencer: takes a (base, count) command, fetches packed input words and
// unpacks them into one element write per cycle, then holds the staged features until consumed.
module feature_loader_ctrl #(
    parameter int unsigned inputWidth   = 256,
    parameter int unsigned elementWidth = 8,
    parameter int unsigned numElements  = 256,
    parameter int unsigned addrWidth    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [addrWidth-1:0]    cmd_base_i,
    input  logic [addrWidth:0]      cmd_count_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [inputWidth-1:0]   in_data_i,
    output logic                    fl_wr_en_o,
    output logic [addrWidth-1:0]    fl_addr_o,
    output logic [elementWidth-1:0] fl_data_o,
    output logic                    feat_valid_o,
    input  logic                    feat_consume_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int unsigned elemsPerWord = inputWidth / elementWidth;
    localparam int unsigned LaneW        = (elemsPerWord > 1) ? $clog2(elemsPerWord) : 1;

    localparam logic [addrWidth:0] CntOne   = 1;
    localparam logic [addrWidth:0] MaxCount = (addrWidth + 1)'(numElements);
    localparam logic [LaneW-1:0]   LaneOne  = 1;
    localparam logic [LaneW-1:0]   LastLane = LaneW'(elemsPerWord - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StUnpack, StHold} state_e;

    state_e                  state_q, state_d;
    logic [addrWidth-1:0]    base_q, base_d;
    logic [addrWidth:0]      count_q, count_d;
    logic [addrWidth:0]      written_q, written_d;
    logic [addrWidth:0]      written_inc;
    logic [LaneW-1:0]        lane_q, lane_d;
    logic [inputWidth-1:0]   word_q, word_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    cmd_legal;
    logic [elementWidth-1:0] lane_data;

    assign cmd_legal   = (cmd_count_i != '0) && (cmd_count_i <= MaxCount);
    assign written_inc = written_q + CntOne;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        written_d = written_q;
        lane_d    = lane_q;
        word_d    = word_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Illegal commands are still consumed; they only raise err_o.
                if (cmd_valid_i) begin
                    if (cmd_legal) begin
                        base_d    = cmd_base_i;
                        count_d   = cmd_count_i;
                        written_d = '0;
                        lane_d    = '0;
                        state_d   = StFetch;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StFetch: begin
                if (in_valid_i) begin
                    word_d  = in_data_i;
                    state_d = StUnpack;
                end
            end
            StUnpack: begin
                written_d = written_inc;
                lane_d    = lane_q + LaneOne;
                if (written_inc == count_q) begin
                    state_d = StHold;
                    done_d  = 1'b1;
                end else if (lane_q == LastLane) begin
                    lane_d  = '0;
                    state_d = StFetch;
                end
            end
            StHold: begin
                if (feat_consume_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            base_q    <= '0;
            count_q   <= '0;
            written_q <= '0;
            lane_q    <= '0;
            word_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            count_q   <= count_d;
            written_q <= written_d;
            lane_q    <= lane_d;
            word_q    <= word_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < int'(elemsPerWord); i++) begin
            if (lane_q == LaneW'(i)) begin
                lane_data = word_q[i*elementWidth +: elementWidth];
            end
        end
    end

    assign cmd_ready_o  = (state_q == StIdle);
    assign in_ready_o   = (state_q == StFetch);
    assign fl_wr_en_o   = (state_q == StUnpack);
    assign feat_valid_o = (state_q == StHold);
    assign busy_o       = (state_q != StIdle);
    assign done_o       = done_q;
    assign err_o        = err_q;

    // Address wraps modulo numElements through natural truncation of the sum.
    assign fl_addr_o = fl_wr_en_o ? (base_q + written_q[addrWidth-1:0]) : '0;
    assign fl_data_o = fl_wr_en_o ? lane_data : '0;

endmodule

// File: tb/tb_feature_loader_ctrl.sv
// Bench for feature_loader_ctrl: table-driven loads, hand-written corner sequences and
// randomized loads checked against an element-list model of each command.
module tb_feature_loader_ctrl;

    localparam int IW  = 256;
    localparam int EW  = 8;
    localparam int NE  = 256;
    localparam int AW  = 8;
    localparam int EPW = IW / EW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_count;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          fl_wr_en;
    logic [AW-1:0] fl_addr;
    logic [EW-1:0] fl_data;
    logic          feat_valid;
    logic          feat_consume;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    feature_loader_ctrl #(
        .inputWidth  (IW),
        .elementWidth(EW),
        .numElements (NE),
        .addrWidth   (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_base_i    (cmd_base),
        .cmd_count_i   (cmd_count),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .fl_wr_en_o    (fl_wr_en),
        .fl_addr_o     (fl_addr),
        .fl_data_o     (fl_data),
        .feat_valid_o  (feat_valid),
        .feat_consume_i(feat_consume),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [AW-1:0] log_addr[$];
    logic [EW-1:0] log_data[$];
    int            done_cnt = 0;
    int            err_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Element writes and pulses observed on the DUT side.
    always @(negedge clk) begin
        if (!rst) begin
            if (fl_wr_en) begin
                log_addr.push_back(fl_addr);
                log_data.push_back(fl_data);
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    function automatic logic [IW-1:0] rand_word();
        logic [IW-1:0] w;
        for (int j = 0; j < IW / 32; j++) w[j*32 +: 32] = $urandom;
        return w;
    endfunction

    // One full legal load: command, word feed with optional stalls, hold, consume.
    task automatic do_load(input int base, input int count, input int stall, input bit stall_rand,
                           input int hold_cycles, input bit pattern, input bit cmd_in_hold);
        int            nwords;
        int            stalls;
        int            s;
        int            tcmd;
        int            tdone;
        int            bad;
        bit            ok;
        logic [IW-1:0] words[$];
        logic [IW-1:0] w;
        logic [AW-1:0] ea[$];
        logic [EW-1:0] ed[$];

        nwords = (count + EPW - 1) / EPW;
        stalls = 0;
        for (int wi = 0; wi < nwords; wi++) begin
            if (pattern) begin
                for (int i = 0; i < EPW; i++) w[i*EW +: EW] = EW'(wi * EPW + i + 1);
            end else begin
                w = rand_word();
            end
            words.push_back(w);
        end
        for (int k = 0; k < count; k++) begin
            w = words[k / EPW];
            ea.push_back(AW'((base + k) % NE));
            ed.push_back(w[(k % EPW)*EW +: EW]);
        end
        clear_log();

        cmd_base  = AW'(base);
        cmd_count = (AW + 1)'(count);
        cmd_valid = 1'b1;
        check("cmd_ready_idle", 32'(cmd_ready), 1);
        tcmd = cyc;
        tick();
        cmd_valid = 1'b0;

        for (int wi = 0; wi < nwords; wi++) begin
            ok = 0;
            for (int t = 0; t < 100; t++) begin
                if (in_ready) begin
                    ok = 1;
                    break;
                end
                tick();
            end
            if (!ok) begin
                check("fetch_timeout", 0, 1);
                return;
            end
            s = stall_rand ? $urandom_range(0, stall) : stall;
            for (int j = 0; j < s; j++) begin
                in_valid = 1'b0;
                tick();
                check("stall_in_ready", 32'(in_ready), 1);
                check("stall_no_write", 32'(fl_wr_en), 0);
            end
            stalls += s;
            in_data  = words[wi];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            in_data  = rand_word();
        end

        ok = 0;
        for (int t = 0; t < 300; t++) begin
            if (done) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            check("done_timeout", 0, 1);
            return;
        end
        tdone = cyc;
        check("latency", 32'(tdone - tcmd), 32'(nwords + stalls + count + 1));
        check("feat_valid_done", 32'(feat_valid), 1);
        check("write_count", 32'(log_addr.size()), 32'(count));
        bad = 0;
        for (int k = 0; k < count && k < log_addr.size(); k++) begin
            if (log_addr[k] !== ea[k] || log_data[k] !== ed[k]) bad++;
        end
        check("write_seq_mismatches", 32'(bad), 0);

        if (cmd_in_hold) begin
            cmd_base  = '0;
            cmd_count = '0;
            cmd_valid = 1'b1;
        end
        for (int h = 0; h < hold_cycles; h++) begin
            tick();
            check("hold_feat_valid", 32'(feat_valid), 1);
            check("hold_done_low", 32'(done), 0);
            check("hold_cmd_ready", 32'(cmd_ready), 0);
            check("hold_busy", 32'(busy), 1);
        end
        feat_consume = 1'b1;
        tick();
        feat_consume = 1'b0;
        check("idle_cmd_ready", 32'(cmd_ready), 1);
        check("idle_feat_valid", 32'(feat_valid), 0);
        check("idle_busy", 32'(busy), 0);
        check("done_once", 32'(done_cnt), 1);
        if (cmd_in_hold) begin
            check("held_cmd_no_err_yet", 32'(err_cnt), 0);
            tick();
            cmd_valid = 1'b0;
            check("held_cmd_err", 32'(err), 1);
            check("held_cmd_idle", 32'(cmd_ready), 1);
            tick();
            check("held_cmd_err_pulse", 32'(err), 0);
        end
    endtask

    task automatic do_illegal(input int count);
        clear_log();
        cmd_base  = AW'($urandom);
        cmd_count = (AW + 1)'(count);
        cmd_valid = 1'b1;
        check("ill_cmd_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        check("ill_err", 32'(err), 1);
        check("ill_busy", 32'(busy), 0);
        check("ill_cmd_ready_after", 32'(cmd_ready), 1);
        tick();
        check("ill_err_pulse", 32'(err), 0);
        check("ill_no_writes", 32'(log_addr.size()), 0);
        check("ill_err_once", 32'(err_cnt), 1);
    endtask

    typedef struct {
        int base;
        int count;
        int stall;
        int hold;
        bit pattern;
        bit exp_err;
        int exp_writes;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit ok;
        int cnt;

        tbl[0] = '{base: 0,   count: 32,  stall: 0, hold: 2, pattern: 1, exp_err: 0, exp_writes: 32};
        tbl[1] = '{base: 0,   count: 40,  stall: 0, hold: 1, pattern: 1, exp_err: 0, exp_writes: 40};
        tbl[2] = '{base: 250, count: 10,  stall: 0, hold: 0, pattern: 0, exp_err: 0, exp_writes: 10};
        tbl[3] = '{base: 17,  count: 0,   stall: 0, hold: 0, pattern: 0, exp_err: 1, exp_writes: 0};
        tbl[4] = '{base: 3,   count: 257, stall: 0, hold: 0, pattern: 0, exp_err: 1, exp_writes: 0};
        tbl[5] = '{base: 5,   count: 33,  stall: 5, hold: 1, pattern: 0, exp_err: 0, exp_writes: 33};
        tbl[6] = '{base: 255, count: 1,   stall: 0, hold: 0, pattern: 1, exp_err: 0, exp_writes: 1};
        tbl[7] = '{base: 7,   count: 256, stall: 1, hold: 1, pattern: 0, exp_err: 0, exp_writes: 256};

        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_base     = '0;
        cmd_count    = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        feat_consume = 1'b0;
        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_wr_en", 32'(fl_wr_en), 0);
        check("rst_addr", 32'(fl_addr), 0);
        check("rst_data", 32'(fl_data), 0);
        check("rst_feat_valid", 32'(feat_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            if (tbl[i].exp_err) do_illegal(tbl[i].count);
            else do_load(tbl[i].base, tbl[i].count, tbl[i].stall, 1'b0, tbl[i].hold,
                         tbl[i].pattern, 1'b0);
            check("tbl_writes", 32'(log_addr.size()), 32'(tbl[i].exp_writes));
            check("tbl_err", 32'(err_cnt), 32'(tbl[i].exp_err));
        end

        // Command held during HOLD must only be taken once back in IDLE.
        do_load(3, 20, 0, 1'b0, 3, 1'b0, 1'b1);

        // Reset in the middle of unpacking.
        clear_log();
        cmd_base  = '0;
        cmd_count = (AW + 1)'(32);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        in_data   = rand_word();
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            if (log_addr.size() == 10) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("mid_reset_reached", 32'(ok), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en", 32'(fl_wr_en), 0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_addr", 32'(fl_addr), 0);
        check("mid_rst_data", 32'(fl_data), 0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_rst_writes", 32'(log_addr.size()), 10);
        check("mid_rst_no_done", 32'(done_cnt), 0);
        check("mid_rst_feat_valid", 32'(feat_valid), 0);
        check("mid_rst_idle", 32'(cmd_ready), 1);
        do_load(100, 32, 0, 1'b0, 0, 1'b1, 1'b0);

        // Randomized loads and illegal commands.
        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 5) == 0) begin
                cnt = ($urandom_range(0, 1) == 0) ? 0 : 257 + int'($urandom_range(0, 254));
                do_illegal(cnt);
            end else begin
                cnt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 256))
                                                  : int'($urandom_range(1, 80));
                do_load(int'($urandom_range(0, 255)), cnt, 3, 1'b1,
                        int'($urandom_range(0, 3)), 1'b0, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/feature_loader_ctrl.md
Name: feature_loader_ctrl

Overview:
Sequencer that fills the element-addressable feature staging register from a wide input stream. Accepts a load command (base element address, element count), pulls packed input words over a valid/ready handshake, and unpacks each word into one element write per cycle (addr, data, write enable). When the load completes, it presents the staged features to the array side and holds them until consumed. Sits between the input buffer/DMA and the feature loader.

Parameters:
inputWidth, 256, width of one packed input word
elementWidth, 8, width of one element
numElements, 256, staging register depth (power of two)
addrWidth, 8, element address width, log2(numElements)
elemsPerWord, inputWidth/elementWidth (32), elements per input word (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cmd_valid_i  in  1  load command valid
cmd_ready_o  out  1  command accepted when high with cmd_valid_i
cmd_base_i  in  addrWidth  first element address
cmd_count_i  in  addrWidth+1  number of elements, 1..numElements
in_valid_i  in  1  input word valid
in_ready_o  out  1  controller can take an input word
in_data_i  in  inputWidth  packed elements, lane 0 = bits [elementWidth-1:0]
fl_wr_en_o  out  1  element write enable to feature loader
fl_addr_o  out  addrWidth  element write address
fl_data_o  out  elementWidth  element write data
feat_valid_o  out  1  staged features complete and stable
feat_consume_i  in  1  array side has taken the features
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle pulse on load completion
err_o  out  1  one-cycle pulse on illegal command

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. Reset forces state IDLE. All counters and the word register are cleared, and every output is 0 except cmd_ready_o, which is 1 in IDLE. Staging register contents are not touched.
- States: IDLE, FETCH, UNPACK, HOLD.
- IDLE: cmd_ready_o=1. On cmd_valid_i and a legal count:
  - latch base, count, and lane=0;
  - go to FETCH next cycle.
- Illegal command (count==0 or count>numElements): the command is consumed, err_o pulses the next cycle, and the state stays IDLE.
- FETCH: in_ready_o=1. On in_valid_i&in_ready_o, register in_data_i and go to UNPACK. With no in_valid_i, wait indefinitely.
- UNPACK, one element per cycle:
  - fl_wr_en_o=1; fl_data_o = lane of the word register; fl_addr_o=(base+written) mod numElements;
  - the written and lane counters increment.
- UNPACK exits:
  - written reaches count: go to HOLD. Unused upper lanes of the last word are discarded.
  - lane reaches elemsPerWord-1 with elements remaining: go to FETCH.
- in_ready_o=0 during UNPACK; no prefetch. Throughput is 1 fetch cycle plus up to 32 write cycles per word.
- Address wrap: base+k wraps modulo numElements (e.g. 255 -> 0). It does not saturate.
- HOLD:
  - feat_valid_o=1, and done_o pulses in the first HOLD cycle.
  - When feat_consume_i is high, go to IDLE next cycle; feat_valid_o drops in that IDLE cycle.
  - feat_consume_i is ignored in all other states.
- cmd_ready_o=0 outside IDLE. Commands presented in FETCH, UNPACK or HOLD are not accepted and must be held by the requester.
- fl_wr_en_o is 0 in IDLE, FETCH and HOLD. fl_addr_o and fl_data_o are don't-care when fl_wr_en_o=0, but must be driven to 0 during reset.
- Reset mid-operation: return to IDLE immediately. A partially written staging register is left as is, and feat_valid_o is not asserted.
- Latency, count=32, word available at once:
  - cmd handshake at cycle 0; FETCH and word handshake at cycle 1;
  - writes at cycles 2..33; HOLD (feat_valid_o=1, done_o) at cycle 34.

Test Plan:
- Full word: base=0, count=32, one word with lane i = i+1 -> addresses 0..31 written with data 1..32 in cycles 2..33; done_o and feat_valid_o at cycle 34; feat_consume_i -> IDLE and cmd_ready_o=1.
- Multi-word: base=0, count=40, two words -> 32 writes, one FETCH cycle, 8 writes (addresses 32..39), lanes 8..31 of word 2 never written, done_o once.
- Wrap: base=250, count=10 -> fl_addr_o sequence 250..255, 0..3.
- Illegal and backpressure: count=0 and count=257 -> err_o pulse, no writes, still IDLE. in_valid_i low 5 cycles in FETCH -> no writes, in_ready_o held at 1, resumes correctly.
- HOLD lock: cmd_valid_i asserted during HOLD -> cmd_ready_o=0 until after feat_consume_i; command then accepted in IDLE.
- Reset mid-UNPACK after 10 writes -> next cycle IDLE, fl_wr_en_o=0, no done_o/feat_valid_o; a new command then completes normally.
